// File: rtl/bus_master_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_master_if_pkg
// Description : Shared definitions for the bus master interface. Holds the
//               access FSM state encodings and the pipeline stall-vector
//               indices of the stages that own a memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_master_if_pkg;

    // Access FSM state encodings
    localparam logic [1:0] c_BUS_IDLE = 2'd0;
    localparam logic [1:0] c_BUS_BUSY = 2'd1;
    localparam logic [1:0] c_BUS_HOLD = 2'd2;

    // Index in the stall vector of the stage owning each memory port
    localparam int c_STALL_BIT_FETCH = 1;
    localparam int c_STALL_BIT_MEM   = 4;

endpackage : bus_master_if_pkg
`default_nettype wire

// File: rtl/bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_master_if
// Description : Wishbone-style bus master for one core memory port (fetch or
//               load/store). Turns a single-cycle core request into a
//               multi-cycle bus handshake, stalls the pipeline until the slave
//               answers, buffers read data while the owning stage is stalled,
//               aborts on flush, and pulses err_o on bus error or timeout.
//
// Ports       : clk, rst (async, active-low)
//               cpu_*      core-side request / write data / read data
//               stall_i    pipeline stall vector, bit STALL_BIT is ours
//               flush_i    abort the current access
//               stallreq_o stall request to the pipeline controller
//               err_o      one-cycle pulse on bus error or timeout
//               wb_*       Wishbone-style master port
// Revision    : 1.0 - initial release
// ============================================================================
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int STALL_W   = 6,
    parameter int STALL_BIT = c_STALL_BIT_FETCH,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_ce_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [DATA_W/8-1:0]   cpu_sel_i,
    input  logic [DATA_W-1:0]     cpu_data_i,
    output logic [DATA_W-1:0]     cpu_data_o,
    input  logic [STALL_W-1:0]    stall_i,
    input  logic                  flush_i,
    output logic                  stallreq_o,
    output logic                  err_o,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic [ADDR_W-1:0]     wb_adr_o,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_we_o,
    output logic [DATA_W/8-1:0]   wb_sel_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o
);

    // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so the
    // declarations stay legal.
    localparam int               c_CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_VAL = c_CNT_W'(TIMEOUT);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [DATA_W-1:0]  r_rd_buf;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic               w_stall_own;
    logic               w_tmo_hit;
    logic               w_busy;
    logic               w_stall_unused;

    // Only our own stage's bit of the stall vector matters
    assign w_stall_own    = stall_i[STALL_BIT];
    assign w_stall_unused = ^stall_i;

    assign w_busy    = (r_state == c_BUS_BUSY);
    assign w_tmo_hit = (TIMEOUT != 0) && (r_cnt == c_TMO_VAL);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_BUS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and combinational core-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        stallreq_o   = 1'b0;
        cpu_data_o   = r_rd_buf;
        case (r_state)
            c_BUS_IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    w_next_state = c_BUS_BUSY;
                end
            end
            c_BUS_BUSY: begin
                stallreq_o = ~wb_ack_i & ~wb_err_i;
                if (flush_i) begin
                    // Flush outranks ack/err: the answer is dropped
                    w_next_state = c_BUS_IDLE;
                end else if (wb_ack_i) begin
                    // Forward bus data straight through in the ack cycle so
                    // a zero-wait slave costs only two cycles
                    cpu_data_o   = wb_dat_i;
                    w_next_state = w_stall_own ? c_BUS_HOLD : c_BUS_IDLE;
                end else if (wb_err_i || w_tmo_hit) begin
                    w_next_state = w_stall_own ? c_BUS_HOLD : c_BUS_IDLE;
                end
            end
            c_BUS_HOLD: begin
                if (!w_stall_own || flush_i) begin
                    w_next_state = c_BUS_IDLE;
                end
            end
            default: begin
                w_next_state = c_BUS_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus outputs, read buffer, watchdog counter, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            r_rd_buf <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_state == c_BUS_IDLE) begin
                if (cpu_ce_i && !flush_i) begin
                    wb_adr_o <= cpu_addr_i;
                    wb_dat_o <= cpu_data_i;
                    wb_we_o  <= cpu_we_i;
                    wb_sel_o <= cpu_sel_i;
                    wb_stb_o <= 1'b1;
                    wb_cyc_o <= 1'b1;
                    r_cnt    <= '0;
                end
            end else if (w_busy) begin
                if (flush_i || wb_ack_i || wb_err_i || w_tmo_hit) begin
                    wb_we_o  <= 1'b0;
                    wb_sel_o <= '0;
                    wb_stb_o <= 1'b0;
                    wb_cyc_o <= 1'b0;
                end
                if (flush_i) begin
                    // aborted: buffer and error flag untouched
                end else if (wb_ack_i) begin
                    if (!wb_we_o) begin
                        r_rd_buf <= wb_dat_i;
                    end
                end else if (wb_err_i || w_tmo_hit) begin
                    r_err    <= 1'b1;
                    r_rd_buf <= '0;
                end else if (r_cnt != c_TMO_VAL) begin
                    // saturating wait-cycle count
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign err_o = r_err;

endmodule : bus_master_if
`default_nettype wire

// File: tb/tb_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_master_if
// Description : Self-checking bench for bus_master_if. A transaction-level
//               model predicts, cycle by cycle, what the core and the bus
//               should see for each access (wait states, hold length,
//               flush, error, timeout, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_master_if;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = 6;
    localparam int SB  = 4;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_ce_i, cpu_we_i, flush_i;
    logic [AW-1:0]   cpu_addr_i;
    logic [DW/8-1:0] cpu_sel_i;
    logic [DW-1:0]   cpu_data_i, cpu_data_o;
    logic [SW-1:0]   stall_i;
    logic            stallreq_o, err_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i, wb_err_i;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_we_o, wb_stb_o, wb_cyc_o;
    logic [DW/8-1:0] wb_sel_o;

    int total = 0;
    int bad   = 0;

    // Model of the last value delivered to the core
    logic [DW-1:0] exp_buf = '0;

    always #5 clk = ~clk;

    bus_master_if #(
        .DATA_W(DW), .ADDR_W(AW), .STALL_W(SW), .STALL_BIT(SB), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stall_i(stall_i), .flush_i(flush_i), .stallreq_o(stallreq_o), .err_o(err_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One access: waits = slave wait states, hold = cycles the owning stage
    // stays stalled after the ack.
    task automatic xact(input logic we, input logic [AW-1:0] addr,
                        input logic [DW/8-1:0] sel, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdata, input int hold);
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr;
        cpu_sel_i = sel; cpu_data_i = wdata; stall_i = '0;
        #1;
        chk("req_stallreq", stallreq_o, 1);
        chk("req_cyc_low", wb_cyc_o, 0);
        chk("req_data", cpu_data_o, exp_buf);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk); #1;
            chk("wait_cyc", wb_cyc_o, 1);
            chk("wait_stb", wb_stb_o, 1);
            chk("wait_adr", wb_adr_o, addr);
            chk("wait_we", wb_we_o, we);
            chk("wait_sel", wb_sel_o, sel);
            if (we) chk("wait_dat", wb_dat_o, wdata);
            chk("wait_stallreq", stallreq_o, 1);
        end
        @(negedge clk);
        wb_ack_i = 1'b1; wb_dat_i = rdata; stall_i[SB] = (hold > 0);
        #1;
        chk("ack_cyc", wb_cyc_o, 1);
        chk("ack_we", wb_we_o, we);
        chk("ack_stallreq", stallreq_o, 0);
        if (!we) begin
            chk("ack_data", cpu_data_o, rdata);
            exp_buf = rdata;
        end
        @(negedge clk);
        wb_ack_i = 1'b0; wb_dat_i = $urandom; cpu_ce_i = 1'b0;
        if (hold == 0) begin
            stall_i = '0;
            #1;
            chk("post_cyc", wb_cyc_o, 0);
            chk("post_stb", wb_stb_o, 0);
            chk("post_err", err_o, 0);
            chk("post_stallreq", stallreq_o, 0);
            chk("post_data", cpu_data_o, exp_buf);
        end else begin
            for (int h = 0; h < hold; h++) begin
                if (h > 0) @(negedge clk);
                cpu_ce_i = 1'b1; stall_i[SB] = 1'b1;
                #1;
                chk("hold_stallreq", stallreq_o, 0);
                chk("hold_cyc", wb_cyc_o, 0);
                chk("hold_data", cpu_data_o, exp_buf);
            end
            @(negedge clk);
            cpu_ce_i = 1'b0; stall_i = '0;
            #1;
            chk("hold_exit_cyc", wb_cyc_o, 0);
            chk("hold_exit_data", cpu_data_o, exp_buf);
        end
    endtask

    // Read answered with error and/or ack in BUSY cycle 1
    task automatic err_read(input logic ack, input logic [DW-1:0] rdata);
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300; cpu_sel_i = 4'hF;
        @(negedge clk);
        cpu_ce_i = 1'b0; wb_err_i = 1'b1; wb_ack_i = ack; wb_dat_i = rdata;
        #1;
        chk("errcyc_stallreq", stallreq_o, 0);
        @(negedge clk);
        wb_err_i = 1'b0; wb_ack_i = 1'b0;
        if (ack) exp_buf = rdata; else exp_buf = '0;
        #1;
        chk("err_pulse", err_o, !ack);
        chk("err_cyc", wb_cyc_o, 0);
        chk("err_data", cpu_data_o, exp_buf);
        @(negedge clk); #1;
        chk("err_pulse_end", err_o, 0);
    endtask

    initial begin
        rst = 1'b0;
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        cpu_data_i = '0; stall_i = '0; flush_i = 1'b0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_data", cpu_data_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Zero-wait read
        xact(1'b0, 32'h100, 4'hF, 32'h0, 0, 32'hDEADBEEF, 0);
        // Write with three wait states; read buffer must survive
        xact(1'b1, 32'h204, 4'b0011, 32'h12345678, 3, 32'hA5A5A5A5, 0);
        chk("write_keeps_buf", cpu_data_o, 32'hDEADBEEF);
        // Read acked while the stage stays stalled three more cycles
        xact(1'b0, 32'h108, 4'hF, 32'h0, 1, 32'hCAFEF00D, 3);

        // Flush in wait cycle 2 together with an ack: answer discarded
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h400; cpu_sel_i = 4'hF;
        @(negedge clk); cpu_ce_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h0BADF00D;
        #1;
        chk("flush_data", cpu_data_o, exp_buf);
        @(negedge clk);
        flush_i = 1'b0; wb_ack_i = 1'b0;
        #1;
        chk("flush_cyc", wb_cyc_o, 0);
        chk("flush_stb", wb_stb_o, 0);
        chk("flush_err", err_o, 0);
        chk("flush_buf", cpu_data_o, exp_buf);
        chk("flush_idle", stallreq_o, 0);

        // Bus error, then simultaneous ack+err (ack wins)
        err_read(1'b0, 32'h11111111);
        err_read(1'b1, 32'h22222222);

        // Timeout: slave never answers
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h500; cpu_sel_i = 4'hF;
        @(negedge clk); cpu_ce_i = 1'b0;
        for (int i = 0; i < TMO + 1; i++) begin
            #1;
            chk("tmo_cyc", wb_cyc_o, 1);
            chk("tmo_err_quiet", err_o, 0);
            @(negedge clk);
        end
        #1;
        exp_buf = '0;
        chk("tmo_err", err_o, 1);
        chk("tmo_cyc_drop", wb_cyc_o, 0);
        chk("tmo_data", cpu_data_o, 0);
        @(negedge clk); #1;
        chk("tmo_err_end", err_o, 0);

        // Reset mid-transaction
        xact(1'b0, 32'h600, 4'hF, 32'h0, 0, 32'h76543210, 0);
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h700;
        @(negedge clk);
        cpu_ce_i = 1'b0;
        #1;
        chk("pre_rst_cyc", wb_cyc_o, 1);
        rst = 1'b0;
        #1;
        exp_buf = '0;
        chk("async_rst_cyc", wb_cyc_o, 0);
        chk("async_rst_stb", wb_stb_o, 0);
        chk("async_rst_adr", wb_adr_o, 0);
        chk("async_rst_data", cpu_data_o, 0);
        @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 32'h104, 4'hF, 32'h0, 0, 32'h13572468, 0);

        // Randomized accesses
        for (int n = 0; n < 16; n++) begin
            xact(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)),
                 $urandom, int'($urandom_range(0, 3)), $urandom,
                 int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_bus_master_if
`default_nettype wire
